// File: rtl/ddr3_bridge_pkg.sv
// Shared sizing helpers for the narrow-to-wide Wishbone bridge into ddr3_top.
// Order FIFO entries are packed as {we, ofs, wide_addr}, wide_addr in the LSBs.
package ddr3_bridge_pkg;

    function automatic int calc_ratio(input int wide_bits, input int narrow_bits);
        return wide_bits / narrow_bits;
    endfunction

    function automatic int calc_ofs_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int fifo_ofs_lsb(input int addr_bits);
        return addr_bits;
    endfunction

    function automatic int fifo_we_bit(input int addr_bits, input int ofs_bits);
        return addr_bits + ofs_bits;
    endfunction

    function automatic int fifo_width(input int addr_bits, input int ofs_bits);
        return 1 + ofs_bits + addr_bits;
    endfunction

endpackage

// File: rtl/ddr3_bridge_order_fifo.sv
// Order FIFO remembering {we, ofs, wide_addr} for every forwarded request so
// read data can be steered back in request order.
module ddr3_bridge_order_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/ddr3_wb_narrow_bridge.sv
// Narrow pipelined Wishbone slave to wide burst-granular ddr3_top Wishbone master,
// with in-order response steering, an optional single-line read cache and abort.
module ddr3_wb_narrow_bridge
    import ddr3_bridge_pkg::*;
#(
    parameter int NARROW_DATA_BITS = 32,
    parameter int WIDE_DATA_BITS   = 512,
    parameter int WIDE_ADDR_BITS   = 24,
    parameter int AUX_WIDTH        = 16,
    parameter int MAX_OUTSTANDING  = 8,
    parameter int OPT_READ_CACHE   = 1,
    localparam int RATIO            = calc_ratio(WIDE_DATA_BITS, NARROW_DATA_BITS),
    localparam int OFS_BITS         = calc_ofs_bits(RATIO),
    localparam int NARROW_ADDR_BITS = WIDE_ADDR_BITS + OFS_BITS
) (
    input  logic                          i_controller_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wb_cyc,
    input  logic                          i_wb_stb,
    input  logic                          i_wb_we,
    input  logic [NARROW_ADDR_BITS-1:0]   i_wb_addr,
    input  logic [NARROW_DATA_BITS-1:0]   i_wb_data,
    input  logic [NARROW_DATA_BITS/8-1:0] i_wb_sel,
    output logic                          o_wb_stall,
    output logic                          o_wb_ack,
    output logic [NARROW_DATA_BITS-1:0]   o_wb_data,
    output logic                          o_ddr_cyc,
    output logic                          o_ddr_stb,
    output logic                          o_ddr_we,
    output logic [WIDE_ADDR_BITS-1:0]     o_ddr_addr,
    output logic [WIDE_DATA_BITS-1:0]     o_ddr_data,
    output logic [WIDE_DATA_BITS/8-1:0]   o_ddr_sel,
    output logic [AUX_WIDTH-1:0]          o_ddr_aux,
    input  logic                          i_ddr_stall,
    input  logic                          i_ddr_ack,
    input  logic [WIDE_DATA_BITS-1:0]     i_ddr_data,
    input  logic [AUX_WIDTH-1:0]          i_ddr_aux
);
    localparam int NSEL    = NARROW_DATA_BITS / 8;
    localparam int WSEL    = WIDE_DATA_BITS / 8;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FIFO_W  = fifo_width(WIDE_ADDR_BITS, OFS_BITS);
    localparam int OFS_LSB = fifo_ofs_lsb(WIDE_ADDR_BITS);
    localparam int WE_BIT  = fifo_we_bit(WIDE_ADDR_BITS, OFS_BITS);

    logic [WIDE_ADDR_BITS-1:0] addr_top;
    logic [OFS_BITS-1:0]       ofs;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_next;
    logic                      accept, abort, ack_eff, cache_hit, fwd, stb_next, fill, merge;
    logic                      cache_valid;
    logic [WIDE_ADDR_BITS-1:0] cache_tag;
    logic [WIDE_DATA_BITS-1:0] cache_line;
    logic [FIFO_W-1:0]         head;
    logic [WIDE_ADDR_BITS-1:0] head_addr;
    logic [OFS_BITS-1:0]       head_ofs;
    logic                      head_we;
    logic                      fifo_empty, fifo_full;

    assign addr_top  = i_wb_addr[NARROW_ADDR_BITS-1:OFS_BITS];
    assign ofs       = i_wb_addr[OFS_BITS-1:0];
    assign head_addr = head[WIDE_ADDR_BITS-1:0];
    assign head_ofs  = head[OFS_LSB +: OFS_BITS];
    assign head_we   = head[WE_BIT];

    assign o_wb_stall = (o_ddr_stb && i_ddr_stall) || (count == CNT_W'(MAX_OUTSTANDING));

    // Handshake: a narrow request is taken when cyc && stb && !stall; a wide
    // request is taken when stb && !i_ddr_stall; each i_ddr_ack retires the FIFO head.
    always_comb begin
        accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
        abort      = !i_wb_cyc && o_ddr_cyc;
        ack_eff    = i_ddr_ack && (count != '0);
        cache_hit  = (OPT_READ_CACHE != 0) && accept && !i_wb_we && cache_valid
                     && (cache_tag == addr_top) && (count == '0) && !o_ddr_stb;
        fwd        = accept && !cache_hit;
        count_next = abort ? '0 : (count + CNT_W'(fwd) - CNT_W'(ack_eff));
        stb_next   = abort ? 1'b0 : (fwd ? 1'b1 : (o_ddr_stb && i_ddr_stall));
        // Fill only when this read is the last thing in flight, so a write
        // merged into the line while the read was pending is never overwritten.
        fill       = (OPT_READ_CACHE != 0) && ack_eff && !head_we && i_wb_cyc
                     && (count == CNT_W'(1)) && !fwd;
        merge      = (OPT_READ_CACHE != 0) && accept && i_wb_we && cache_valid
                     && (cache_tag == addr_top);
    end

    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count      <= '0;
            o_ddr_cyc  <= 1'b0;
            o_ddr_stb  <= 1'b0;
            o_ddr_we   <= 1'b0;
            o_ddr_addr <= '0;
            o_ddr_data <= '0;
            o_ddr_sel  <= '0;
            o_ddr_aux  <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_data  <= '0;
        end else begin
            count     <= count_next;
            o_ddr_stb <= stb_next;
            o_ddr_cyc <= stb_next || (count_next != '0);
            if (fwd) begin
                o_ddr_we   <= i_wb_we;
                o_ddr_addr <= addr_top;
                o_ddr_data <= {RATIO{i_wb_data}};
                o_ddr_sel  <= WSEL'(i_wb_sel) << (ofs * NSEL);
                o_ddr_aux  <= AUX_WIDTH'({i_wb_we, ofs});
            end
            o_wb_ack <= (ack_eff && i_wb_cyc) || cache_hit;
            if (ack_eff)
                o_wb_data <= head_we ? '0 : i_ddr_data[head_ofs*NARROW_DATA_BITS +: NARROW_DATA_BITS];
            else if (cache_hit)
                o_wb_data <= cache_line[ofs*NARROW_DATA_BITS +: NARROW_DATA_BITS];
        end
    end

    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_line  <= '0;
        end else if (abort) begin
            cache_valid <= 1'b0;
        end else if (fill) begin
            cache_valid <= 1'b1;
            cache_tag   <= head_addr;
            cache_line  <= i_ddr_data;
        end else if (merge) begin
            for (int b = 0; b < NSEL; b++) begin
                if (i_wb_sel[b])
                    cache_line[ofs*NARROW_DATA_BITS + b*8 +: 8] <= i_wb_data[b*8 +: 8];
            end
        end
    end

    ddr3_bridge_order_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk   (i_controller_clk),
        .rst_n (i_rst_n),
        .push  (fwd),
        .pop   (ack_eff),
        .flush (abort),
        .din   ({i_wb_we, ofs, addr_top}),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // ddr3_top echoes the request aux, so it must match the head being retired.
    always @(posedge i_controller_clk) begin
        if (i_rst_n) begin
            if (ack_eff) assert (i_ddr_aux == AUX_WIDTH'({head_we, head_ofs}));
            if (ack_eff) assert (!fifo_empty);
            if (fwd)     assert (!fifo_full);
        end
    end

endmodule
